// File: rtl/lsu_axi_master.sv
// AXI-lite master bridging single LSU load/store requests to AR/R or AW/W/B transactions.
// One transaction in flight; completion is returned as a one-cycle rsp_valid pulse.
module lsu_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    // Handshake rule on every channel: a transfer happens on a rising clk edge where
    // valid && ready; a raised valid and its payload hold until that edge, and no
    // valid is ever derived combinationally from the matching ready.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AR   = 3'd1;
    localparam logic [2:0] ST_R    = 3'd2;
    localparam logic [2:0] ST_AW_W = 3'd3;
    localparam logic [2:0] ST_B    = 3'd4;
    localparam logic [2:0] ST_RSP  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              aw_hs, w_hs;

    // All channel controls decode from registered state only.
    assign req_ready = (state_q == ST_IDLE);
    assign arvalid   = (state_q == ST_AR);
    assign rready    = (state_q == ST_R);
    assign awvalid   = (state_q == ST_AW_W) && !aw_done_q;
    assign wvalid    = (state_q == ST_AW_W) && !w_done_q;
    assign bready    = (state_q == ST_B);
    assign rsp_valid = (state_q == ST_RSP);

    assign araddr    = addr_q;
    assign awaddr    = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_we ? ST_AW_W : ST_AR;
                end
            end
            ST_AR: begin
                if (arready) state_d = ST_R;
            end
            ST_R: begin
                if (rvalid) begin
                    rdata_d = rdata;
                    err_d   = (rresp != 2'b00);
                    state_d = ST_RSP;
                end
            end
            ST_AW_W: begin
                // Both flags may complete in the same cycle; B is entered as soon as both are done.
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) state_d = ST_B;
            end
            ST_B: begin
                if (bvalid) begin
                    err_d   = (bresp != 2'b00);
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: a hand-driven AXI-lite slave with cycle-exact expectations.
module tb_lsu_axi_master;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    int n_checks = 0;
    int n_pass   = 0;

    lsu_axi_master #(.ADDR_W(32), .DATA_W(32), .STRB_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb;
    endtask

    task automatic zero_wait_load(input string tag, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [1:0] resp,
                                  input logic exp_err);
        drive_req(1'b0, addr, 32'h0, 4'h0);
        check({tag, "_c0_req_ready"}, req_ready, 1);
        step();
        req_valid = 1'b0;
        check({tag, "_c1_arvalid"}, arvalid, 1);
        check({tag, "_c1_araddr"}, araddr, addr);
        arready = 1'b1;
        step();
        arready = 1'b0;
        check({tag, "_c2_arvalid"}, arvalid, 0);
        check({tag, "_c2_rready"}, rready, 1);
        rvalid = 1'b1; rdata = data; rresp = resp;
        step();
        rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        check({tag, "_c3_rsp_valid"}, rsp_valid, 1);
        check({tag, "_c3_rsp_rdata"}, rsp_rdata, data);
        check({tag, "_c3_rsp_err"}, rsp_err, exp_err);
        step();
        check({tag, "_c4_rsp_valid"}, rsp_valid, 0);
        check({tag, "_c4_req_ready"}, req_ready, 1);
    endtask

    task automatic zero_wait_store(input string tag, input logic [31:0] addr,
                                   input logic [31:0] data, input logic [3:0] strb,
                                   input logic [1:0] resp, input logic exp_err,
                                   input logic [31:0] exp_rdata);
        drive_req(1'b1, addr, data, strb);
        step();
        req_valid = 1'b0;
        check({tag, "_c1_awvalid"}, awvalid, 1);
        check({tag, "_c1_wvalid"}, wvalid, 1);
        check({tag, "_c1_awaddr"}, awaddr, addr);
        check({tag, "_c1_wdata"}, wdata, data);
        check({tag, "_c1_wstrb"}, wstrb, strb);
        awready = 1'b1; wready = 1'b1;
        step();
        awready = 1'b0; wready = 1'b0;
        check({tag, "_c2_awvalid"}, awvalid, 0);
        check({tag, "_c2_wvalid"}, wvalid, 0);
        check({tag, "_c2_bready"}, bready, 1);
        bvalid = 1'b1; bresp = resp;
        step();
        bvalid = 1'b0; bresp = 2'b00;
        check({tag, "_c3_rsp_valid"}, rsp_valid, 1);
        check({tag, "_c3_rsp_err"}, rsp_err, exp_err);
        check({tag, "_c3_rsp_rdata"}, rsp_rdata, exp_rdata);
        step();
        check({tag, "_c4_rsp_valid"}, rsp_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        arready = 0; rdata = 0; rresp = 0; rvalid = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
        step();
        step();
        rst = 1'b0;
        step();

        // reset state
        check("rst_req_ready", req_ready, 1);
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_bready", bready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_araddr", araddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wstrb", wstrb, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);

        zero_wait_load("ld0", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 1'b0);

        // load with arready delayed 3 cycles and rvalid 2 more
        drive_req(1'b0, 32'h8000_0044, 32'h0, 4'h0);
        step();
        req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("ldw_c%0d_arvalid", c), arvalid, 1);
            check($sformatf("ldw_c%0d_araddr", c), araddr, 32'h8000_0044);
            check($sformatf("ldw_c%0d_req_ready", c), req_ready, 0);
            if (c == 4) arready = 1'b1;
            step();
        end
        arready = 1'b0;
        for (int c = 5; c <= 7; c++) begin
            check($sformatf("ldw_c%0d_arvalid", c), arvalid, 0);
            check($sformatf("ldw_c%0d_rready", c), rready, 1);
            check($sformatf("ldw_c%0d_rsp_valid", c), rsp_valid, 0);
            if (c == 7) begin rvalid = 1'b1; rdata = 32'hCAFE_F00D; end
            step();
        end
        rvalid = 1'b0; rdata = 32'h0;
        check("ldw_c8_rsp_valid", rsp_valid, 1);
        check("ldw_c8_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        check("ldw_c8_req_ready", req_ready, 0);
        step();
        check("ldw_c9_rsp_valid", rsp_valid, 0);
        check("ldw_c9_req_ready", req_ready, 1);

        // store with W accepted at cycle 1, AW at cycle 4, B at cycle 6
        drive_req(1'b1, 32'h8000_0020, 32'h1234_5678, 4'b0011);
        step();
        req_valid = 1'b0;
        check("sts_c1_wvalid", wvalid, 1);
        check("sts_c1_awvalid", awvalid, 1);
        wready = 1'b1;
        step();
        wready = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            check($sformatf("sts_c%0d_wvalid", c), wvalid, 0);
            check($sformatf("sts_c%0d_awvalid", c), awvalid, 1);
            check($sformatf("sts_c%0d_awaddr", c), awaddr, 32'h8000_0020);
            check($sformatf("sts_c%0d_bready", c), bready, 0);
            if (c == 4) awready = 1'b1;
            step();
        end
        awready = 1'b0;
        check("sts_c5_awvalid", awvalid, 0);
        check("sts_c5_bready", bready, 1);
        check("sts_c5_rsp_valid", rsp_valid, 0);
        step();
        check("sts_c6_bready", bready, 1);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        check("sts_c7_rsp_valid", rsp_valid, 1);
        check("sts_c7_rsp_err", rsp_err, 0);
        check("sts_c7_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        step();
        check("sts_c8_rsp_valid", rsp_valid, 0);

        // zero-wait store with an empty strobe, then error responses
        zero_wait_store("st0", 32'h8000_0030, 32'hA5A5_5A5A, 4'b0000, 2'b00, 1'b0, 32'hCAFE_F00D);
        zero_wait_load("lderr", 32'h8000_0050, 32'h1111_2222, 2'b10, 1'b1);
        zero_wait_store("sterr", 32'h8000_0060, 32'h0BAD_0BAD, 4'b1111, 2'b11, 1'b1, 32'h1111_2222);

        // reset while AW/W are pending
        drive_req(1'b1, 32'h8000_0070, 32'h7777_7777, 4'b1111);
        step();
        req_valid = 1'b0;
        check("rstm_pre_awvalid", awvalid, 1);
        rst = 1'b1;
        #1;
        check("rstm_awvalid", awvalid, 0);
        check("rstm_wvalid", wvalid, 0);
        check("rstm_bready", bready, 0);
        check("rstm_rsp_valid", rsp_valid, 0);
        step();
        check("rstm_hold_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        step();
        check("rstm_rel_req_ready", req_ready, 1);
        check("rstm_rel_rsp_valid", rsp_valid, 0);
        zero_wait_load("ldpost", 32'h8000_0080, 32'h5555_AAAA, 2'b00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
